// File: rtl/syn_syscall.sv
// -----------------------------------------------------------------------------
// syn_syscall
//
// Syscall service unit for a single-cycle core. It watches the decoded syscall
// flag together with $v0/$a0 and implements three services:
//   v0 = 10       : halt the core (terminal until reset)
//   v0 = 34 or 1  : latch $a0 into the display register
//   v0 = 50       : pause the core until a resume pulse arrives
// Any other service code is a NOP. Service codes are compared on all 32 bits.
//
// Optional feature (macro SYSCALL_CNT_EN): when defined, the syscall_cnt port
// exists and counts accepted syscalls (16-bit, wrapping). The default build,
// with the macro undefined, has neither the port nor the counter.
//
// Ports:
//   clk          in   core clock, rising-edge
//   rst          in   asynchronous active-high reset
//   en           in   core step enable; syscalls are only taken when 1
//   syscall_en   in   decoded syscall flag for the current instruction
//   data_v0      in   [31:0] service code ($v0)
//   data_a0      in   [31:0] service argument ($a0)
//   resume       in   single-cycle continue pulse (leaves PAUSE)
//   stall        out  combinational; blocks PC and architectural writes
//   halted       out  registered; 1 while in HALT
//   display      out  [31:0] registered last displayed value
//   display_vld  out  registered; 1 once any display service executed
//   syscall_cnt  out  [15:0] accepted-syscall count (SYSCALL_CNT_EN only)
//
// Handshake note: there is no valid/ready pair here. A syscall is "accepted"
// in any cycle where the unit is in RUN, en=1 and syscall_en=1; stall is the
// only back-pressure signal and it takes effect in the same cycle.
// -----------------------------------------------------------------------------
module syn_syscall (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        syscall_en,
    input  logic [31:0] data_v0,
    input  logic [31:0] data_a0,
    input  logic        resume,
    output logic        stall,
    output logic        halted,
    output logic [31:0] display,
    output logic        display_vld
`ifdef SYSCALL_CNT_EN
    ,
    output logic [15:0] syscall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] CODE_HALT  = 32'd10;
    localparam logic [31:0] CODE_DISP  = 32'd34;
    localparam logic [31:0] CODE_DISP1 = 32'd1;
    localparam logic [31:0] CODE_PAUSE = 32'd50;

    state_t state;
    logic   skip;     // swallow the re-presented syscall after a PAUSE

    logic accept;
    logic take;
    logic is_halt;
    logic is_disp;
    logic is_pause;

    assign accept   = (state == ST_RUN) && en && syscall_en;
    // The first accept after leaving PAUSE is the same syscall instruction
    // again; it is consumed without any effect.
    assign take     = accept && !skip;
    assign is_halt  = (data_v0 == CODE_HALT);
    assign is_disp  = (data_v0 == CODE_DISP) || (data_v0 == CODE_DISP1);
    assign is_pause = (data_v0 == CODE_PAUSE);

    // Zero-latency stall; forced low during reset so the core is never held
    // while rst is asserted.
    assign stall = !rst &&
                   ((state != ST_RUN) || (take && (is_halt || is_pause)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            skip        <= 1'b0;
            halted      <= 1'b0;
            display     <= 32'd0;
            display_vld <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && skip) begin
                        skip <= 1'b0;
                    end else if (take) begin
                        if (is_halt) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else if (is_pause) begin
                            state <= ST_PAUSE;
                            skip  <= 1'b1;
                        end else if (is_disp) begin
                            display     <= data_a0;
                            display_vld <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (resume) begin
                        state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    // Terminal: only reset leaves HALT.
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef SYSCALL_CNT_EN
    // Counts every effective accept, NOP codes included; the swallowed
    // re-presentation after PAUSE is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syscall_cnt <= 16'd0;
        end else if (take) begin
            syscall_cnt <= syscall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_syn_syscall.sv
module tb_syn_syscall;

    logic        clk;
    logic        rst;
    logic        en;
    logic        syscall_en;
    logic [31:0] data_v0;
    logic [31:0] data_a0;
    logic        resume;
    logic        stall;
    logic        halted;
    logic [31:0] display;
    logic        display_vld;
`ifdef SYSCALL_CNT_EN
    logic [15:0] syscall_cnt;
`endif

    int total;
    int bad;

    syn_syscall dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .syscall_en  (syscall_en),
        .data_v0     (data_v0),
        .data_a0     (data_a0),
        .resume      (resume),
        .stall       (stall),
        .halted      (halted),
        .display     (display),
        .display_vld (display_vld)
`ifdef SYSCALL_CNT_EN
        ,
        .syscall_cnt (syscall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic s, input logic [31:0] v0,
                         input logic [31:0] a0, input logic r);
        @(negedge clk);
        en = e; syscall_en = s; data_v0 = v0; data_a0 = a0; resume = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0; syscall_en = 0; data_v0 = 0; data_a0 = 0; resume = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic        sys;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        res;
        logic        exp_stall;
        logic        exp_halted;
        logic [31:0] exp_disp;
        logic        exp_vld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic s, logic [31:0] v0, logic [31:0] a0,
                                logic r, logic st, logic h, logic [31:0] d, logic vl);
        vec_t v;
        v.en = e; v.sys = s; v.v0 = v0; v.a0 = a0; v.res = r;
        v.exp_stall = st; v.exp_halted = h; v.exp_disp = d; v.exp_vld = vl;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Abstract service model: mode 0=running, 1=paused, 2=halted.
    int          m_mode;
    bit          m_skip;
    logic [31:0] m_disp;
    bit          m_vld;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_mode = 0; m_skip = 0; m_disp = 0; m_vld = 0; m_cnt = 0;
    endtask

    function automatic bit model_stall(bit e, bit s, logic [31:0] v0);
        if (m_mode != 0) return 1;
        if (e && s && !m_skip && (v0 == 10 || v0 == 50)) return 1;
        return 0;
    endfunction

    task automatic model_step(bit e, bit s, logic [31:0] v0, logic [31:0] a0, bit r);
        if (m_mode == 1) begin
            if (r) m_mode = 0;
        end else if (m_mode == 0 && e && s) begin
            if (m_skip) begin
                m_skip = 0;
            end else begin
                m_cnt = m_cnt + 16'd1;
                if (v0 == 10) m_mode = 2;
                else if (v0 == 50) begin m_mode = 1; m_skip = 1; end
                else if (v0 == 34 || v0 == 1) begin m_disp = a0; m_vld = 1; end
            end
        end
    endtask

    function automatic logic [31:0] pick_v0();
        int k;
        k = $urandom_range(0, 99);
        if (k < 2)  return 32'd10;
        if (k < 20) return 32'd50;
        if (k < 40) return 32'd34;
        if (k < 50) return 32'd1;
        if (k < 60) return 32'h0000_010A;
        if (k < 65) return 32'h0000_0122;
        if (k < 75) return 32'd0;
        return $urandom;
    endfunction

    // ---------------- main test ----------------
    initial begin
        total = 0; bad = 0;
        rst = 1; en = 0; syscall_en = 0; data_v0 = 0; data_a0 = 0; resume = 0;
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_display", display, 32'd0);
        chk("reset_vld", {31'd0, display_vld}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // --- table-driven directed sequence ---
        //            en sys v0           a0            res st h  disp          vld
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 0, 0, 32'd0,        0));
        vecs.push_back(mk(1, 1, 32'd34,  32'hDEADBEEF, 0, 0, 0, 32'd0,        0));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 0, 0, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 1, 32'd1,   32'h12345678, 0, 0, 0, 32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(0, 1, 32'd10,  32'd0,        0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 1, 32'h10A, 32'd0,        0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(0, 1, 32'd34,  32'h55,       0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        1, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 1, 32'd50,  32'd0,        0, 1, 0, 32'h12345678, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(i[0], 0, 32'd0, 32'd0,   0, 1, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        1, 1, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 1, 32'd50,  32'd0,        0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 1, 32'd34,  32'hA5,       0, 0, 0, 32'h12345678, 1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 0, 0, 32'hA5,       1));
        vecs.push_back(mk(1, 1, 32'd10,  32'd0,        0, 1, 0, 32'hA5,       1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 1, 1, 32'hA5,       1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        1, 1, 1, 32'hA5,       1));
        vecs.push_back(mk(1, 1, 32'd34,  32'h77,       0, 1, 1, 32'hA5,       1));
        vecs.push_back(mk(1, 0, 32'd0,   32'd0,        0, 1, 1, 32'hA5,       1));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].sys, vecs[i].v0, vecs[i].a0, vecs[i].res);
            chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
            chk($sformatf("vec%0d_display", i), display, vecs[i].exp_disp);
            chk($sformatf("vec%0d_vld", i), {31'd0, display_vld}, {31'd0, vecs[i].exp_vld});
        end

        // --- reset out of HALT ---
        @(negedge clk);
        rst = 1; en = 0; syscall_en = 0; resume = 0;
        #1;
        chk("halt_rst_stall", {31'd0, stall}, 32'd0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        chk("halt_rst_display", display, 32'd0);
        chk("halt_rst_vld", {31'd0, display_vld}, 32'd0);
        @(negedge clk);
        rst = 0;

        // --- asynchronous reset mid-PAUSE ---
        drive(1, 1, 32'd50, 32'd0, 0);
        chk("pause_enter_stall", {31'd0, stall}, 32'd1);
        drive(1, 0, 32'd0, 32'd0, 0);
        chk("paused_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        #2;
        rst = 0;
        // Back in RUN with the skip flag cleared: a fresh PAUSE must be taken.
        drive(1, 1, 32'd50, 32'd0, 0);
        chk("post_rst_pause_stall", {31'd0, stall}, 32'd1);
        drive(1, 0, 32'd0, 32'd0, 1);
        chk("resume_cycle_stall", {31'd0, stall}, 32'd1);
        drive(1, 0, 32'd0, 32'd0, 0);
        chk("after_resume_stall", {31'd0, stall}, 32'd0);
        // Skip flag still set: an unrelated display syscall is the swallowed one.
        drive(1, 1, 32'd34, 32'h11, 0);
        drive(1, 0, 32'd0, 32'd0, 0);
        chk("skip_swallow_vld", {31'd0, display_vld}, 32'd0);

        // --- randomized run against the reference model ---
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit e, s, r, do_rst;
            logic [31:0] v0, a0;
            e  = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 3) == 0);
            v0 = pick_v0();
            a0 = $urandom;
            do_rst = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            @(negedge clk);
            en = e; syscall_en = s; data_v0 = v0; data_a0 = a0; resume = r;
            rst = do_rst;
            if (do_rst) model_reset();
            #1;
            chk("rnd_stall", {31'd0, stall}, {31'd0, (!do_rst && model_stall(e, s, v0))});
            chk("rnd_halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
            chk("rnd_display", display, m_disp);
            chk("rnd_vld", {31'd0, display_vld}, {31'd0, m_vld});
`ifdef SYSCALL_CNT_EN
            chk("rnd_cnt", {16'd0, syscall_cnt}, {16'd0, m_cnt});
`endif
            if (!do_rst) model_step(e, s, v0, a0, r);
        end
        @(negedge clk);
        rst = 0;

`ifdef SYSCALL_CNT_EN
        // --- counter wrap ---
        do_reset();
        @(negedge clk);
        en = 1; syscall_en = 1; data_v0 = 0; data_a0 = 0; resume = 0;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        en = 0; syscall_en = 0;
        chk("cnt_wrap", {16'd0, syscall_cnt}, 32'd0);
        en = 1; syscall_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 0; syscall_en = 0;
        chk("cnt_plus3", {16'd0, syscall_cnt}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
